// File: rtl/sp_ram_burst_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : sp_ram_burst_ctrl_if                                        |
// | Description: Command, write-beat, read-beat and RAM-side signal bundle   |
// |              for the sp_ram burst controller.                            |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
interface sp_ram_burst_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  // command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  // write beat channel
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  // read beat channel
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  // burst completion
  logic          done;
  // RAM side
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  // controller view
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wvalid, rready, ram_dout,
    output cmd_ready, wready, rdata, rvalid, done, ram_en, ram_addr, ram_din
  );

  // requester / RAM view
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wvalid, rready, ram_dout,
    input  cmd_ready, wready, rdata, rvalid, done, ram_en, ram_addr, ram_din
  );
endinterface
`default_nettype wire

// File: rtl/sp_ram_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : sp_ram_burst_ctrl                                           |
// | Description: Write/read burst controller driving a single-port RAM with  |
// |              a 1-cycle registered read. One burst at a time, addresses   |
// |              wrap modulo 2**AW. Optional beat statistics are enabled by  |
// |              defining SP_RAM_SEQ_STATS_EN.                               |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module sp_ram_burst_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
`ifdef SP_RAM_SEQ_STATS_EN
  , parameter int CW = 16
`endif
) (
  input  wire                clk,
  input  wire                rst,        // synchronous, active-low
  sp_ram_burst_ctrl_if.slave bus
`ifdef SP_RAM_SEQ_STATS_EN
  , output logic [CW-1:0]    wr_beats,
  output logic [CW-1:0]      rd_beats
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_RD_FILL = 2'd2,
    S_READ    = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [AW-1:0] cnt_q, cnt_nxt;
  logic          done_q, done_nxt;
  // last values presented to the RAM, so IDLE keeps the bus quiet
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] din_hold;

  logic          cmd_ready;
  logic          wready;
  logic          rvalid;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          wr_acc;
  logic          rd_acc;

  // State, burst address/count and done pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      addr_hold <= '0;
      din_hold  <= '0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      cnt_q     <= cnt_nxt;
      done_q    <= done_nxt;
      addr_hold <= ram_addr;
      din_hold  <= ram_din;
    end
  end

  // Next-state logic and combinational RAM / handshake outputs
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    cnt_nxt   = cnt_q;
    done_nxt  = 1'b0;
    cmd_ready = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    ram_en    = 1'b0;
    ram_addr  = addr_hold;
    ram_din   = din_hold;
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_nxt  = bus.cmd_addr;
          cnt_nxt   = bus.cmd_len;
          state_nxt = bus.cmd_write ? S_WRITE : S_RD_FILL;
        end
      end
      S_WRITE: begin
        wready   = 1'b1;
        ram_addr = addr_q;
        ram_din  = bus.wdata;
        // a beat presented while reset is asserted must not reach the RAM
        ram_en   = bus.wvalid & rst;
        if (bus.wvalid) begin
          wr_acc   = 1'b1;
          addr_nxt = addr_q + 1'b1;
          if (cnt_q == '0) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_q - 1'b1;
          end
        end
      end
      S_RD_FILL: begin
        // RAM registers the first word at the end of this cycle
        ram_addr  = addr_q;
        state_nxt = S_READ;
      end
      S_READ: begin
        rvalid   = 1'b1;
        ram_addr = addr_q;
        if (bus.rready) begin
          // prefetch the following word so it is ready next cycle
          rd_acc   = 1'b1;
          ram_addr = addr_q + 1'b1;
          addr_nxt = addr_q + 1'b1;
          if (cnt_q == '0) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_q - 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.wready    = wready;
  assign bus.rvalid    = rvalid;
  assign bus.rdata     = bus.ram_dout;
  assign bus.done      = done_q;
  assign bus.ram_en    = ram_en;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_din   = ram_din;

`ifdef SP_RAM_SEQ_STATS_EN
  // Saturating counters of accepted write and read beats
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_beats <= '0;
      rd_beats <= '0;
    end else begin
      if (wr_acc && (wr_beats != {CW{1'b1}})) wr_beats <= wr_beats + 1'b1;
      if (rd_acc && (rd_beats != {CW{1'b1}})) rd_beats <= rd_beats + 1'b1;
    end
  end
`else
  // beat-accept strobes only feed the optional statistics
  logic unused_acc;
  assign unused_acc = wr_acc ^ rd_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_sp_ram_burst_ctrl                                        |
// | Description: Scoreboard bench for sp_ram_burst_ctrl with a behavioural   |
// |              single-port RAM. Honours SP_RAM_SEQ_STATS_EN.               |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_sp_ram_burst_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef SP_RAM_SEQ_STATS_EN
  localparam int CW = 3;
  localparam int SAT = (1 << CW) - 1;
  logic [CW-1:0] wr_beats, rd_beats;
  int wr_model = 0;
  int rd_model = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sp_ram_burst_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  sp_ram_burst_ctrl #(
    .AW(AW),
    .DW(DW)
`ifdef SP_RAM_SEQ_STATS_EN
    , .CW(CW)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SP_RAM_SEQ_STATS_EN
    , .wr_beats(wr_beats),
    .rd_beats(rd_beats)
`endif
  );

  always #5 clk = ~clk;

  // behavioural single-port RAM: write when en=1, registered read when en=0
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ram_q;
  bit            ram_clear = 1'b1;
  always @(posedge clk) begin
    if (ram_clear) begin
      foreach (ram_mem[i]) ram_mem[i] <= '0;
    end else if (bus.ram_en) begin
      ram_mem[bus.ram_addr] <= bus.ram_din;
    end
    if (!rst) ram_q <= '0;
    else if (!bus.ram_en) ram_q <= ram_mem[bus.ram_addr];
  end
  assign bus.ram_dout = ram_q;

  // reference model: plain memory image and expected read stream
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wdata_q[$];
  int            exp_done = 0;
  int            done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares every accepted read beat and checks stalled beats hold
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (hold_v && bus.rvalid) chk("rdata_stable", bus.rdata, hold_d);
      if (bus.rvalid && bus.rready) begin
        if (exp_q.size() == 0) chk("rd_unexpected_beat", 1, 0);
        else chk("rdata", bus.rdata, exp_q.pop_front());
      end
      if (bus.done) done_seen <= done_seen + 1;
    end
    hold_v <= rst && bus.rvalid && !bus.rready;
    hold_d <= bus.rdata;
  end

  // present a command; returns one cycle after the accepting edge (+1)
  task automatic issue_cmd(input bit wr, input logic [7:0] a, input logic [7:0] l, output bit ok);
    int guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    while (!bus.cmd_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = bus.cmd_ready;
    if (!ok) chk("cmd_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] l, input bit gaps);
    bit ok;
    bit v;
    int beat = 0;
    int cyc = 0;
    logic [7:0] ea;
    issue_cmd(1'b1, a, l, ok);
    if (!ok) return;
    chk("wready_in_write", bus.wready, 1);
    while (beat <= int'(l) && cyc < 4 * (int'(l) + 1) + 64) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.wvalid = v;
      bus.wdata  = (wdata_q.size() != 0 && v) ? wdata_q.pop_front() : DW'($urandom);
      #1;
      ea = a + 8'(beat);
      if (v) begin
        chk("ram_en_beat", bus.ram_en, 1);
        chk("ram_addr_beat", bus.ram_addr, ea);
        chk("ram_din_beat", bus.ram_din, bus.wdata);
        model_mem[ea] = bus.wdata;
        beat++;
`ifdef SP_RAM_SEQ_STATS_EN
        wr_model++;
`endif
      end else begin
        chk("ram_en_stall", bus.ram_en, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.wvalid = 1'b0;
    chk("done_after_write", bus.done, 1);
    chk("wready_after_write", bus.wready, 0);
    exp_done++;
    @(posedge clk); #1;
    chk("done_one_cycle_w", bus.done, 0);
  endtask

  // mode 0: rready always 1, 1: random, 2: pattern 1,0,0,1,1,1 then 1
  task automatic do_read(input logic [7:0] a, input logic [7:0] l, input int mode);
    bit ok;
    bit r;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int acc = 0;
    int cyc = 0;
    int k = 0;
    logic [7:0] ea;
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 8'(i);
      exp_q.push_back(model_mem[ea]);
    end
    bus.rready = 1'b0;
    issue_cmd(1'b0, a, l, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    chk("rvalid_during_fill", bus.rvalid, 0);
    @(posedge clk); #1;
    chk("rvalid_latency", bus.rvalid, 1);
    while (acc <= int'(l) && cyc < 4 * (int'(l) + 1) + 64) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: r = (k < 6) ? pat[k] : 1'b1;
      endcase
      bus.rready = r;
      if (bus.rvalid) begin
        k++;
        if (r) begin
          acc++;
`ifdef SP_RAM_SEQ_STATS_EN
          rd_model++;
`endif
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    if (acc <= int'(l)) chk("read_beat_timeout", acc, int'(l) + 1);
    chk("done_after_read", bus.done, 1);
    chk("rvalid_after_read", bus.rvalid, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    exp_done++;
    @(posedge clk); #1;
    chk("done_one_cycle_r", bus.done, 0);
  endtask

`ifdef SP_RAM_SEQ_STATS_EN
  task automatic chk_stats();
    chk("wr_beats", wr_beats, (wr_model > SAT) ? SAT : wr_model);
    chk("rd_beats", rd_beats, (rd_model > SAT) ? SAT : rd_model);
  endtask
`endif

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int beat;
    logic [7:0] a, l;
    foreach (model_mem[i]) model_mem[i] = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wdata     = '0;
    bus.wvalid    = 1'b0;
    bus.rready    = 1'b0;

    // reset held two cycles
    @(posedge clk); #1;
    ram_clear = 1'b0;
    @(posedge clk); #1;
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_din", bus.ram_din, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);

    // single beat write then read at F2
    wdata_q.push_back(8'hA7);
    do_write(8'hF2, 8'd0, 1'b0);
    do_read(8'hF2, 8'd0, 0);

    // wrapping 4-beat burst FE..01
    wdata_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(8'hFE, 8'd3, 1'b0);
    do_read(8'hFE, 8'd3, 0);
`ifdef SP_RAM_SEQ_STATS_EN
    chk_stats();
`endif

    // back-pressure pattern on a 4-beat read
    do_read(8'hFE, 8'd3, 2);

    // reset after three beats of an 8-beat write with gaps
    issue_cmd(1'b1, 8'h40, 8'd7, ok);
    beat = 0;
    for (int c = 0; c < 40 && beat < 3; c++) begin
      bus.wvalid = (c % 2 == 0);
      bus.wdata  = DW'($urandom);
      if (bus.wvalid) begin
        model_mem[8'h40 + 8'(beat)] = bus.wdata;
        beat++;
      end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_wready", bus.wready, 0);
    chk("midrst_rvalid", bus.rvalid, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_ram_en", bus.ram_en, 0);
    chk("midrst_ram_addr", bus.ram_addr, 0);
    rst = 1'b1;
`ifdef SP_RAM_SEQ_STATS_EN
    wr_model = 0;
    rd_model = 0;
    chk_stats();
`endif
    @(posedge clk); #1;
    do_read(8'h40, 8'd7, 0);

    // randomized bursts with stalls and back-pressure
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom);
      l = 8'($urandom_range(0, 15));
      do_write(a, l, 1'b1);
      do_read(a, l, (i % 2 == 0) ? 1 : 0);
      a = 8'($urandom);
      do_read(a, 8'($urandom_range(0, 7)), 1);
    end

    // maximum-length burst
    do_write(8'h80, 8'd255, 1'b1);
    do_read(8'h80, 8'd255, 1);
`ifdef SP_RAM_SEQ_STATS_EN
    chk_stats();
`endif

    @(posedge clk); #1;
    chk("done_pulse_count", done_seen, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
